// File: rtl/fifo_uart_drain_pkg.sv
// Shared FSM encoding and baud divisor helper for the FIFO-to-UART drain block.
// Pure declarations; no latency or backpressure of its own.
package fifo_uart_drain_pkg;

    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        CHECK   = 6'b000010,
        RD_WAIT = 6'b000100,
        LOAD    = 6'b001000,
        SEND    = 6'b010000,
        DONE    = 6'b100000
    } state_t;

    // Clocks per serial bit; the fractional part is dropped.
    function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/fifo_uart_drain_baud_gen.sv
// Bit-period tick generator: counts 0..BPS_CNT-1, tick on the last count; clr holds it at 0.
// Latency: first tick BPS_CNT clocks after clr drops; no backpressure.
module uart_baud_gen #(
    parameter int BPS_CNT = 434
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(BPS_CNT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_drain.sv
// Drains BURST_LEN bytes from a standard-mode FIFO onto an 8N1 UART line per start pulse.
// Latency: txd falls 2 clocks after fifo_rd_en; waits indefinitely while the FIFO is empty.
module fifo_uart_drain
    import fifo_uart_drain_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 115200,
    parameter int BURST_LEN = 256
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_rd_en,
    output logic       uart_txd,
    output logic       busy,
    output logic       done,
    output logic [8:0] byte_cnt
);

    localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam logic [8:0] BURST_END = 9'(BURST_LEN);

    state_t     state;
    logic [8:0] shreg;      // {stop bit, data}; shifted out LSB first
    logic [3:0] bit_idx;
    logic       baud_clr;
    logic       baud_tick;

    // Baud counter only runs in SEND, so LOAD always starts a frame from zero.
    assign baud_clr = (state != SEND);

    uart_baud_gen #(
        .BPS_CNT (BPS_CNT)
    ) u_baud_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (baud_clr),
        .tick      (baud_tick)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            uart_txd   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_cnt   <= '0;
            shreg      <= '1;
            bit_idx    <= '0;
        end else begin
            fifo_rd_en <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (byte_cnt == BURST_END) begin
                        state <= DONE;
                    end else if (!fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        state      <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shreg    <= {1'b1, fifo_rd_data};
                    uart_txd <= 1'b0;
                    bit_idx  <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    if (baud_tick) begin
                        // Tenth tick closes the stop bit; line is already high.
                        if (bit_idx == 4'd9) begin
                            byte_cnt <= byte_cnt + 9'd1;
                            uart_txd <= 1'b1;
                            state    <= CHECK;
                        end else begin
                            uart_txd <= shreg[0];
                            shreg    <= {1'b1, shreg[8:1]};
                            bit_idx  <= bit_idx + 4'd1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench: FIFO model, serial frame decoder and timing monitor around fifo_uart_drain.
module tb_fifo_uart_drain;

    localparam int CLK_FREQ  = 1000;
    localparam int UART_BPS  = 90;
    localparam int BURST_LEN = 256;
    localparam int B         = 11;   // 1000 / 90, truncated

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_rd_en;
    logic       uart_txd;
    logic       busy;
    logic       done;
    logic [8:0] byte_cnt;

    always #5 sys_clk = ~sys_clk;

    fifo_uart_drain #(
        .CLK_FREQ  (CLK_FREQ),
        .UART_BPS  (UART_BPS),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .uart_txd     (uart_txd),
        .busy         (busy),
        .done         (done),
        .byte_cnt     (byte_cnt)
    );

    // Standard-mode FIFO: data appears the clock after the read strobe.
    logic [7:0] fmem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge sys_clk) begin
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_rd_data <= fmem[rd_ptr % 1024];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // Line monitor: decodes frames and records timing violations.
    int         cyc = 0;
    logic       prev_txd = 1'b1;
    logic       prev_rd = 1'b0;
    logic       in_frame = 1'b0;
    int         t0 = 0;
    int         off = 0;
    logic [9:0] bits = '0;
    logic       frame_bad = 1'b0;
    int         last_end = 0;
    logic       last_valid = 1'b0;
    int         last_rd = -100;
    logic [7:0] rx_mem [0:511];
    int         rx_cnt = 0;
    int         n_fram_err = 0;
    int         n_gap_bad = 0;
    int         n_lat_bad = 0;
    int         n_rd_empty = 0;
    int         n_rd_wide = 0;
    int         n_rd = 0;
    int         n_done = 0;

    initial begin
        forever begin
            @(negedge sys_clk);
            cyc = cyc + 1;
            if (!sys_rst_n) begin
                in_frame   = 1'b0;
                last_valid = 1'b0;
                prev_txd   = 1'b1;
                prev_rd    = 1'b0;
            end else begin
                if (fifo_rd_en && fifo_empty) n_rd_empty = n_rd_empty + 1;
                if (fifo_rd_en && prev_rd)    n_rd_wide  = n_rd_wide + 1;
                if (fifo_rd_en && !prev_rd)   n_rd       = n_rd + 1;
                if (fifo_rd_en)               last_rd    = cyc;
                if (done)                     n_done     = n_done + 1;
                if (in_frame) begin
                    off = cyc - t0;
                    if (off % B == 0) bits[off / B] = uart_txd;
                    else if (uart_txd !== bits[off / B]) frame_bad = 1'b1;
                    if (off == 10 * B - 1) begin
                        in_frame = 1'b0;
                        if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || frame_bad) n_fram_err = n_fram_err + 1;
                        rx_mem[rx_cnt % 512] = bits[8:1];
                        rx_cnt     = rx_cnt + 1;
                        last_end   = cyc;
                        last_valid = 1'b1;
                    end
                end else if (prev_txd === 1'b1 && uart_txd === 1'b0) begin
                    in_frame  = 1'b1;
                    t0        = cyc;
                    bits      = '0;
                    frame_bad = 1'b0;
                    if (cyc - last_rd != 2) n_lat_bad = n_lat_bad + 1;
                    if (last_valid && (cyc - last_end - 1 != 3)) n_gap_bad = n_gap_bad + 1;
                end else if (uart_txd !== 1'b1) begin
                    n_fram_err = n_fram_err + 1;
                end
                prev_txd = uart_txd;
                prev_rd  = fifo_rd_en;
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        fmem[wr_ptr % 1024] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        repeat (3) tick();
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start(input string tag);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check(tag, busy, 1);
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int b;
        b = budget;
        while (rx_cnt < n && b > 0) begin
            tick();
            b = b - 1;
        end
        check(tag, rx_cnt, n);
    endtask

    task automatic wait_offset(input int target, input int budget, input string tag);
        int b;
        b = budget;
        while (!(in_frame && (cyc - t0) >= target) && b > 0) begin
            tick();
            b = b - 1;
        end
        check(tag, in_frame, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base;
    int done_base;
    int rd_base;
    int b;
    logic [7:0] rnd [0:5];

    initial begin
        repeat (3) tick();
        check("rst_txd",      uart_txd,   1);
        check("rst_rd_en",    fifo_rd_en, 0);
        check("rst_busy",     busy,       0);
        check("rst_done",     done,       0);
        check("rst_byte_cnt", byte_cnt,   0);
        sys_rst_n = 1'b1;
        tick();

        // Single 0x55 frame
        push(8'h55);
        base    = rx_cnt;
        rd_base = n_rd;
        pulse_start("t1_busy");
        wait_rx(base + 1, 20 * B, "t1_frame_seen");
        check("t1_data", rx_mem[base % 512], 8'h55);
        repeat (3) tick();
        check("t1_byte_cnt", byte_cnt, 1);
        check("t1_busy_open", busy, 1);
        check("t1_rd_pulses", n_rd - rd_base, 1);
        check("t1_latency", n_lat_bad, 0);
        check("t1_framing", n_fram_err, 0);
        check("t1_rd_width", n_rd_wide, 0);

        // Empty FIFO: no reads, idle line, then a late push
        do_reset();
        base = rx_cnt;
        pulse_start("t2_busy");
        repeat (1000) tick();
        check("t2_no_frame", rx_cnt, base);
        check("t2_txd_idle", uart_txd, 1);
        check("t2_no_rd_empty", n_rd_empty, 0);
        check("t2_byte_cnt0", byte_cnt, 0);
        push(8'hA3);
        wait_offset(3 * B, 20 * B, "t2_frame_started");
        pulse_start("t2_restart_busy");
        wait_rx(base + 1, 20 * B, "t2_frame_seen");
        check("t2_data", rx_mem[base % 512], 8'hA3);
        repeat (3) tick();
        check("t2_byte_cnt", byte_cnt, 1);
        check("t2_framing", n_fram_err, 0);

        // Reset during d3 of 0xF0, then drain the rest
        do_reset();
        push(8'hF0);
        push(8'h11);
        push(8'h22);
        base      = rx_cnt;
        done_base = n_done;
        pulse_start("t3_busy");
        wait_offset(4 * B + 2, 20 * B, "t3_reach_d3");
        check("t3_txd_before", uart_txd, 0);
        sys_rst_n = 1'b0;
        #1;
        check("t3_txd_async", uart_txd, 1);
        check("t3_byte_cnt_async", byte_cnt, 0);
        check("t3_busy_async", busy, 0);
        repeat (2) tick();
        sys_rst_n = 1'b1;
        repeat (50) tick();
        check("t3_no_partial", rx_cnt, base);
        check("t3_no_done", n_done - done_base, 0);
        check("t3_idle_busy", busy, 0);
        pulse_start("t3_restart_busy");
        wait_rx(base + 2, 30 * B, "t3_frames_seen");
        check("t3_data0", rx_mem[base % 512], 8'h11);
        check("t3_data1", rx_mem[(base + 1) % 512], 8'h22);
        repeat (3) tick();
        check("t3_byte_cnt", byte_cnt, 2);
        check("t3_gap", n_gap_bad, 0);

        // Full 256-byte burst
        do_reset();
        for (int i = 0; i < 256; i++) push(i[7:0]);
        base      = rx_cnt;
        done_base = n_done;
        pulse_start("t4_busy");
        b = 256 * (10 * B + 3) + 200;
        while (n_done == done_base && b > 0) begin
            tick();
            b = b - 1;
        end
        check("t4_done_seen", n_done - done_base, 1);
        check("t4_byte_cnt_done", byte_cnt, 256);
        check("t4_busy_low", busy, 0);
        check("t4_frame_count", rx_cnt - base, 256);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("t4_data_%0d", i), rx_mem[(base + i) % 512], i);
        end
        repeat (20) tick();
        check("t4_single_done", n_done - done_base, 1);
        check("t4_byte_cnt_hold", byte_cnt, 256);
        check("t4_gap", n_gap_bad, 0);
        check("t4_latency", n_lat_bad, 0);
        check("t4_framing", n_fram_err, 0);
        check("t4_rd_empty", n_rd_empty, 0);
        check("t4_rd_width", n_rd_wide, 0);

        // Random payload loopback
        do_reset();
        for (int i = 0; i < 6; i++) begin
            rnd[i] = 8'($urandom_range(0, 255));
            push(rnd[i]);
        end
        base = rx_cnt;
        pulse_start("t5_busy");
        wait_rx(base + 6, 6 * (10 * B + 3) + 100, "t5_frames_seen");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t5_data_%0d", i), rx_mem[(base + i) % 512], rnd[i]);
        end
        check("t5_framing", n_fram_err, 0);
        check("t5_gap", n_gap_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_uart_drain.md
FIFO_UART_DRAIN -- requirements
Module: fifo_uart_drain

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200, serial baud rate.
REQ-003 Parameter BURST_LEN, default 256, number of bytes drained per start command.
REQ-004 sys_clk  input  1  system clock; all logic SHALL be clocked on the rising edge.
REQ-005 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle burst request; SHALL be ignored while busy=1.
REQ-007 fifo_empty  input  1  empty flag of the upstream standard-mode (non-FWFT) FIFO.
REQ-008 fifo_rd_data  input  8  FIFO read data, valid one clock after fifo_rd_en.
REQ-009 fifo_rd_en  output  1  FIFO read strobe, registered.
REQ-010 uart_txd  output  1  8N1 serial line, idle high, registered.
REQ-011 busy  output  1  high from the clock after start is accepted until the clock after done.
REQ-012 done  output  1  single-cycle pulse when a burst completes.
REQ-013 byte_cnt  output  9  bytes fully transmitted in the current burst.

Function
REQ-014 BPS_CNT SHALL equal CLK_FREQ/UART_BPS with integer truncation (434 at defaults).
REQ-015 FSM states SHALL be IDLE, CHECK, RD_WAIT, LOAD, SEND, DONE.
REQ-016 IDLE: when start=1, clear byte_cnt, set busy, and go to CHECK.
REQ-017 CHECK: if byte_cnt==BURST_LEN, go to DONE; else if fifo_empty=0, pulse fifo_rd_en for exactly one clock and go to RD_WAIT; else remain in CHECK with no timeout.
REQ-018 RD_WAIT: one clock; no outputs change.
REQ-019 LOAD: capture fifo_rd_data into the shift register, drive uart_txd=0 (start bit), clear the baud counter, and go to SEND.
REQ-020 The falling edge of uart_txd SHALL occur exactly 2 clocks after the edge on which fifo_rd_en rises.
REQ-021 SEND: frame order SHALL be start bit 0, data bits d0..d7 LSB first, then stop bit 1; each bit SHALL be held for exactly BPS_CNT clocks.
REQ-022 The total frame SHALL last 10*BPS_CNT clocks, measured from the falling edge to the end of the stop bit.
REQ-023 At the end of the stop bit, byte_cnt SHALL increment by 1 and the FSM SHALL return to CHECK; uart_txd SHALL remain high.
REQ-024 Back-to-back bytes SHALL be separated by an idle-high gap of exactly 3 clocks (CHECK, RD_WAIT, LOAD) when the FIFO is non-empty.
REQ-025 DONE: assert done for one clock, clear busy, and go to IDLE.
REQ-026 fifo_rd_en SHALL never be asserted while fifo_empty=1, nor outside CHECK.
REQ-027 Changes on fifo_empty or start during RD_WAIT, LOAD, or SEND SHALL have no effect.
REQ-028 With BURST_LEN=256, byte_cnt SHALL reach 256 without wrap; the 9-bit width is mandatory.
REQ-029 An illegal state encoding SHALL recover to IDLE on the next clock with uart_txd=1.

Reset
REQ-030 On sys_rst_n=0, outputs SHALL immediately become: uart_txd=1, fifo_rd_en=0, busy=0, done=0, byte_cnt=0; state SHALL become IDLE and the baud counter 0.
REQ-031 A reset asserted mid-frame SHALL abort the frame with no partial byte counted; after release, the block SHALL wait for a new start.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (one-hot, 6 bits) and the BPS_CNT computation function.
REQ-033 One sub-module, uart_baud_gen, SHALL provide a bit-period tick (counter 0..BPS_CNT-1, synchronous clear input); all other logic SHALL reside in fifo_uart_drain.

Verification
REQ-034 Preload FIFO with 0x55, then pulse start -> fifo_rd_en high 1 clock; txd low 2 clocks later; bits 0,1,0,1,0,1,0,1,0,1 each 434 clocks; byte_cnt=1.
REQ-035 Preload FIFO with 256 bytes 0x00..0xFF, then pulse start -> 256 frames decoded in order; inter-frame gap 3 clocks; exactly one done pulse; byte_cnt=256; busy low after done.
REQ-036 Leave FIFO empty, pulse start, and push 0xA3 after 1000 clocks -> no fifo_rd_en while empty; txd stays 1; frame 0xA3 sent after the push.
REQ-037 Pulse start again during an active burst -> no effect; byte_cnt and frame timing are unchanged.
REQ-038 Assert reset during bit d3 of 0xF0 -> txd=1 immediately; byte_cnt=0; no done; a new start drains the remaining FIFO data correctly.
REQ-039 Loop txd back into the team's uart_rx with random bytes -> received bytes match the FIFO contents in order, with no framing errors.
